// File: rtl/cla_pkg.sv
// Shared constants for the pipelined carry-lookahead adder/subtractor.
// GROUP_W  : width of one carry-lookahead group.
// FLAGS_W  : width of the optional status flag bus.
// FLAG_*   : bit positions inside the flag bus ({ovf, neg, zero}).
package cla_pkg;

  localparam int unsigned GROUP_W   = 4;
  localparam int unsigned FLAGS_W   = 3;
  localparam int unsigned FLAG_OVF  = 2;
  localparam int unsigned FLAG_NEG  = 1;
  localparam int unsigned FLAG_ZERO = 0;

endpackage

// File: rtl/cla4_group.sv
// Combinational 4-bit carry-lookahead group.
// Ports: a, b  - group operand bits
//        cin   - carry into the group
//        s     - group sum bits
//        cout  - carry out of the group
//        gp/gg - group propagate / generate for the next lookahead level
module cla4_group
  import cla_pkg::*;
(
  input  logic [GROUP_W-1:0] a,
  input  logic [GROUP_W-1:0] b,
  input  logic               cin,
  output logic [GROUP_W-1:0] s,
  output logic               cout,
  output logic               gp,
  output logic               gg
);

  logic [GROUP_W-1:0] p;
  logic [GROUP_W-1:0] g;
  logic [GROUP_W:0]   c;

  // Flat lookahead: every internal carry is a two-level function of p/g/cin.
  always_comb begin
    p    = a ^ b;
    g    = a & b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    gp   = &p;
    c[4] = gg | (gp & cin);
    s    = p ^ c[GROUP_W-1:0];
    cout = c[4];
  end

endmodule

// File: rtl/pipe_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// Stage k resolves GROUPS_PER_STAGE 4-bit groups using the carry registered by
// stage k-1; unresolved operand bits ride along in shrinking skew registers and
// resolved sum bits accumulate in growing deskew registers.
// Ports: clk, rst_n (async active-low)
//        in_valid/in_ready, sub, a, b   - operation input (sub=1: a-b)
//        out_valid/out_ready, sum, c_out - result (borrow = !c_out when subtracting)
//        flags {ovf, neg, zero}          - only when ADDSUB_FLAGS_EN is defined
module pipe_cla_addsub
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH            = 16,
  parameter int unsigned GROUPS_PER_STAGE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef ADDSUB_FLAGS_EN
  ,
  output logic [FLAGS_W-1:0] flags
`endif
);

  localparam int unsigned GPS = GROUPS_PER_STAGE;
  localparam int unsigned SW  = GROUP_W * GPS;
  localparam int unsigned L   = WIDTH / SW;

  // Whole pipeline moves together; a stalled output freezes every stage.
  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < L; k++) begin : g_stg
    localparam int unsigned RW_IN  = WIDTH - SW * $unsigned(k);
    localparam int unsigned DONE_W = SW * ($unsigned(k) + 1);

    logic [RW_IN-1:0]  a_in;
    logic [RW_IN-1:0]  b_in;
    logic              c_in;
    logic              v_in;
    logic [SW-1:0]     s_grp;
    logic [GPS:0]      gc;
    logic [GPS-1:0]    gp;
    logic [GPS-1:0]    gg;
    logic [GPS-1:0]    gco;
    logic [DONE_W-1:0] s_new;
    logic [DONE_W-1:0] s_d, s_q;
    logic              c_d, c_q;
    logic              v_d, v_q;

    // Stage inputs: the ports for stage 0, otherwise the previous stage's registers.
    if (k == 0) begin : g_src
      assign a_in  = a;
      assign b_in  = b ^ {WIDTH{sub}};
      assign c_in  = sub;
      assign v_in  = in_valid;
      assign s_new = s_grp;
    end else begin : g_src
      assign a_in  = g_stg[k-1].g_skew.a_q;
      assign b_in  = g_stg[k-1].g_skew.b_q;
      assign c_in  = g_stg[k-1].c_q;
      assign v_in  = g_stg[k-1].v_q;
      assign s_new = {s_grp, g_stg[k-1].s_q};
    end

    for (genvar j = 0; j < GPS; j++) begin : g_grp
      cla4_group u_grp (
        .a    (a_in[GROUP_W*j +: GROUP_W]),
        .b    (b_in[GROUP_W*j +: GROUP_W]),
        .cin  (gc[j]),
        .s    (s_grp[GROUP_W*j +: GROUP_W]),
        .cout (gco[j]),
        .gp   (gp[j]),
        .gg   (gg[j])
      );
    end

    // Second-level lookahead across the groups of this stage.
    always_comb begin
      gc[0] = c_in;
      for (int j = 0; j < GPS; j++) begin
        gc[j+1] = gg[j] | (gp[j] & gc[j]);
      end
    end

    // Group ripple carries duplicate the lookahead chain.
    logic unused_gco;
    assign unused_gco = ^gco;

    // Data loads only for a real operation; a bubble just clears valid.
    always_comb begin
      v_d = v_q;
      c_d = c_q;
      s_d = s_q;
      if (advance) begin
        v_d = v_in;
        if (v_in) begin
          c_d = gc[GPS];
          s_d = s_new;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else begin
        v_q <= v_d;
        c_q <= c_d;
        s_q <= s_d;
      end
    end

    // Operand bits for groups not yet resolved; absent after the last stage.
    if (k < L - 1) begin : g_skew
      localparam int unsigned SKW = RW_IN - SW;
      logic [SKW-1:0] a_d, a_q;
      logic [SKW-1:0] b_d, b_q;

      always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (advance && v_in) begin
          a_d = a_in[RW_IN-1:SW];
          b_d = b_in[RW_IN-1:SW];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end
  end

  assign out_valid = g_stg[L-1].v_q;
  assign sum       = g_stg[L-1].s_q;
  assign c_out     = g_stg[L-1].c_q;

`ifdef ADDSUB_FLAGS_EN
  logic [FLAGS_W-1:0] flags_d, flags_q;
  logic [WIDTH-1:0]   sum_new;
  logic               msb_cin;

  // Carry into the MSB recovered from the MSB's sum and operand bits.
  assign sum_new = g_stg[L-1].s_new;
  assign msb_cin = g_stg[L-1].s_grp[SW-1] ^ g_stg[L-1].a_in[SW-1] ^ g_stg[L-1].b_in[SW-1];

  always_comb begin
    flags_d = flags_q;
    if (advance && g_stg[L-1].v_in) begin
      flags_d[FLAG_OVF]  = msb_cin ^ g_stg[L-1].gc[GPS];
      flags_d[FLAG_NEG]  = sum_new[WIDTH-1];
      flags_d[FLAG_ZERO] = (sum_new == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flags_q <= '0;
    else        flags_q <= flags_d;
  end

  assign flags = flags_q;
`endif

endmodule

// File: tb/tb_pipe_cla_addsub.sv
// Scoreboard bench for pipe_cla_addsub (WIDTH=16, GROUPS_PER_STAGE=1, 4 stages).
// Stimulus pushes hand-computed expectations; a negedge monitor pops and compares
// whenever a result is handed off. Flags are compared when ADDSUB_FLAGS_EN is defined.
module tb_pipe_cla_addsub;

  typedef struct {
    logic [15:0] sum;
    logic        c;
    logic [2:0]  fl;
  } exp_t;

  exp_t sb[$];
  int   chk_cnt  = 0;
  int   err_cnt  = 0;
  int   accepted = 0;
  int   retired  = 0;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        in_valid  = 1'b0;
  logic        sub       = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] a         = '0;
  logic [15:0] b         = '0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] sum;
  logic        c_out;
`ifdef ADDSUB_FLAGS_EN
  logic [2:0]  flags;
`endif

  pipe_cla_addsub #(.WIDTH(16), .GROUPS_PER_STAGE(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sub       (sub),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out)
`ifdef ADDSUB_FLAGS_EN
    ,
    .flags     (flags)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Presents one operation from posedge+1 and holds it until accepted.
  task automatic send(input logic s, input logic [15:0] xa, input logic [15:0] xb,
                      input logic [15:0] es, input logic ec, input logic [2:0] ef);
    bit   ok = 1'b0;
    int   n  = 0;
    exp_t e;
    in_valid = 1'b1;
    sub      = s;
    a        = xa;
    b        = xb;
    while (!ok) begin
      @(negedge clk);
      ok = in_ready;
      if (ok) begin
        e.sum = es;
        e.c   = ec;
        e.fl  = ef;
        sb.push_back(e);
        accepted++;
      end
      @(posedge clk);
      #1;
      n++;
      if (!ok && n > 50) begin
        chk_cnt++;
        err_cnt++;
        $display("FAIL accept_timeout a=%h b=%h", xa, xb);
        ok = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  // Called at posedge+1 just after the acceptance edge; result due after 4 edges total.
  task automatic check_latency(input string name);
    repeat (2) @(posedge clk);
    #1;
    check({name, "_lat3"}, 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check({name, "_lat4"}, 32'(out_valid), 32'd1);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() > 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check({name, "_drain"}, 32'(sb.size()), 32'd0);
  endtask

  // Monitor: a handshake is due at the next edge when out_valid && out_ready here.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk_cnt++;
          err_cnt++;
          $display("FAIL unexpected_result actual=%h expected=none", sum);
        end else begin
          e = sb.pop_front();
          retired++;
          check("sum", 32'(sum), 32'(e.sum));
          check("c_out", 32'(c_out), 32'(e.c));
`ifdef ADDSUB_FLAGS_EN
          check("flags", 32'(flags), 32'(e.fl));
`endif
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_c_out", 32'(c_out), 32'd0);
`ifdef ADDSUB_FLAGS_EN
    check("rst_flags", 32'(flags), 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_in_ready", 32'(in_ready), 32'd1);

    // Directed vectors: expected {sum, c_out, {ovf,neg,zero}}
    send(1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 3'b000);
    check_latency("add_1234");
    send(1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 3'b001);
    send(1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 3'b010);
    send(1'b1, 16'h0007, 16'h0005, 16'h0002, 1'b1, 3'b000);
    send(1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 3'b110);
    send(1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 3'b100);
    send(1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b1, 3'b001);
    drain("directed");

    // Eight back-to-back ops with out_ready low for 3 cycles from cycle 6
    fork
      begin
        send(1'b0, 16'h0001, 16'h00FF, 16'h0100, 1'b0, 3'b000);
        send(1'b1, 16'h1111, 16'h0111, 16'h1000, 1'b1, 3'b000);
        send(1'b0, 16'hFFFE, 16'h0003, 16'h0001, 1'b1, 3'b000);
        send(1'b1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 3'b010);
        send(1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 3'b101);
        send(1'b0, 16'h4000, 16'h4000, 16'h8000, 1'b0, 3'b110);
        send(1'b1, 16'hABCD, 16'hABCD, 16'h0000, 1'b1, 3'b001);
        send(1'b0, 16'h1234, 16'hEDCB, 16'hFFFF, 1'b0, 3'b010);
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("stall_in_ready", 32'(in_ready), 32'd0);
          check("stall_out_valid", 32'(out_valid), 32'd1);
          if (sb.size() > 0) check("stall_sum_held", 32'(sum), 32'(sb[0].sum));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain("burst");
    check("retired_count", 32'(retired), 32'(accepted));

    // Reset with three ops in flight
    send(1'b0, 16'h1111, 16'h2222, 16'h3333, 1'b0, 3'b000);
    send(1'b0, 16'h0F0F, 16'hF0F0, 16'hFFFF, 1'b0, 3'b010);
    send(1'b1, 16'h0003, 16'h0001, 16'h0002, 1'b1, 3'b000);
    @(posedge clk);
    #2;
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_sum", 32'(sum), 32'd0);
    check("midrst_c_out", 32'(c_out), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check("midrst_rel_in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("no_stale_result", 32'(seen), 32'd0);
    @(posedge clk);
    #1;
    send(1'b0, 16'h0100, 16'h0200, 16'h0300, 1'b0, 3'b000);
    check_latency("post_rst");
    drain("post_rst");

    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/pipe_cla_addsub.md
PIPE_CLA_ADDSUB -- requirements
Module: pipe_cla_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width; legal values are multiples of 4, minimum 4.
REQ-002 SHALL have parameter GROUPS_PER_STAGE, default 1, number of 4-bit CLA groups evaluated per pipeline stage; WIDTH/4 SHALL be divisible by it.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, operation presented.
REQ-006 SHALL have port in_ready, output, 1, operation accepted when in_valid && in_ready.
REQ-007 SHALL have port sub, input, 1, 0 = A+B, 1 = A-B.
REQ-008 SHALL have ports a and b, input, WIDTH each, operands.
REQ-009 SHALL have port out_valid, output, 1, result present.
REQ-010 SHALL have port out_ready, input, 1, result consumed when out_valid && out_ready.
REQ-011 SHALL have port sum, output, WIDTH, result.
REQ-012 SHALL have port c_out, output, 1, raw carry out of MSB; in subtract mode borrow = !c_out.
REQ-013 SHALL have port flags, output, 3, {ovf, neg, zero}, present only when ADDSUB_FLAGS_EN is defined.

Function
REQ-014 SHALL compute a + (b XOR {WIDTH{sub}}) + sub, modulo 2^WIDTH, with the carry out on c_out.
REQ-015 SHALL use a pipeline of L = WIDTH/(4*GROUPS_PER_STAGE) stages; stage k SHALL resolve groups k*GPS .. (k+1)*GPS-1 using the carry registered from stage k-1.
REQ-016 SHALL skew-register operand bits for later groups and deskew-register completed sum bits, so a result appears exactly L cycles after acceptance when there is no stall.
REQ-017 SHALL carry a per-stage valid bit; bubbles SHALL propagate without producing out_valid.
REQ-018 SHALL define advance = !out_valid || out_ready, and drive in_ready = advance combinationally.
REQ-019 SHALL move all stages one step when advance is high and hold every stage unchanged when advance is low.
REQ-020 SHALL hold sum, c_out and flags stable while out_valid && !out_ready.
REQ-021 SHALL, when full with out_ready high, accept one operation and retire one in the same cycle; throughput is 1 op/cycle.
REQ-022 SHALL deliver results in acceptance order, with no loss or duplication.
REQ-023 SHALL leave every stage's data unchanged, with valid cleared, when in_valid is low on an advance cycle.

Reset
REQ-024 SHALL, while rst_n is low, immediately clear every valid bit and force out_valid=0, sum=0, c_out=0 and flags=0.
REQ-025 SHALL discard all in-flight operations on a reset mid-operation; no stale result SHALL appear after release.
REQ-026 SHALL drive in_ready=1 in the first cycle after reset release.

Configuration
REQ-027 SHALL compile in the flags output and its pipeline registers when ADDSUB_FLAGS_EN is defined, otherwise omit both.
REQ-028 SHALL define the flags, when enabled, as: ovf = carry into MSB XOR carry out of MSB; neg = sum[WIDTH-1]; zero = (sum == 0); all aligned with sum.
REQ-029 SHALL keep sum, c_out and latency identical with and without ADDSUB_FLAGS_EN.

Structure
REQ-030 SHALL place GROUP_W = 4 and the flag bit-index constants (FLAG_OVF = 2, FLAG_NEG = 1, FLAG_ZERO = 0) in the shared package cla_pkg.
REQ-031 SHALL implement each 4-bit group as the combinational sub-module cla4_group (inputs a, b, cin; outputs s, cout, gp, gg), instantiated WIDTH/4 times.

Verification
REQ-032 SHALL check (WIDTH=16, GPS=1, L=4) add 0x1234+0x4321 -> sum=0x5555, c_out=0, out_valid exactly 4 cycles after acceptance.
REQ-033 SHALL check 0xFFFF+0x0001 -> sum=0x0000, c_out=1, zero=1, ovf=0.
REQ-034 SHALL check sub 0x0005-0x0007 -> sum=0xFFFE, c_out=0, neg=1; sub 0x0007-0x0005 -> sum=0x0002, c_out=1.
REQ-035 SHALL check 0x7FFF+0x0001 -> sum=0x8000, ovf=1, neg=1.
REQ-036 SHALL check 8 back-to-back ops with out_ready low for 3 cycles from cycle 6 -> in_ready low during the stall, outputs held, all 8 results in order, none lost.
REQ-037 SHALL check rst_n pulsed low with 3 ops in flight -> out_valid=0 immediately, no result emitted after release, and the next op returns correctly after 4 cycles.
